led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 128 ++++++++++++
 tb/tb_led_pattern_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: millisecond prescaler, step-period counter and
// four display modes (static, blink, chase, bar graph) on a registered LED bus.
module led_pattern_gen #(
    parameter int unsigned LED_WIDTH = 8,
    parameter int unsigned TICK_DIV  = 125000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic [1:0]           mode_i,
    input  logic [LED_WIDTH-1:0] pattern_i,
    input  logic [9:0]           period_i,
    input  logic [13:0]          level_i,
    output logic [LED_WIDTH-1:0] val_o,
    output logic                 step_o
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BAR    = 2'd3
    } mode_e;

    mode_e                mode_q,    mode_d;
    logic [LED_WIDTH-1:0] pattern_q, pattern_d;
    logic [9:0]           period_q,  period_d;
    logic [PW-1:0]        presc_q,   presc_d;
    logic [9:0]           per_q,     per_d;
    logic                 phase_q,   phase_d;
    logic [LED_WIDTH-1:0] val_q,     val_d;

    logic                 tick;
    logic                 per_end;
    logic                 step;
    logic [LED_WIDTH-1:0] rot;

    // Lit count is the top three bits plus one for any nonzero remainder.
    function automatic logic [LED_WIDTH-1:0] bar_of(input logic [13:0] lvl);
        logic [3:0]           n;
        logic [LED_WIDTH-1:0] b;
        n = {1'b0, lvl[13:11]} + {3'b000, |lvl[10:0]};
        b = '0;
        for (int unsigned i = 0; i < LED_WIDTH; i++) begin
            b[i] = (i < 32'(n));
        end
        return b;
    endfunction

    assign tick    = (presc_q == PRESC_MAX);
    assign per_end = (per_q == period_q - 10'd1);
    assign step    = tick && per_end && !cfg_load;

    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < LED_WIDTH; i++) begin
            rot[i] = val_q[(i + LED_WIDTH - 1) % LED_WIDTH];
        end
    end

    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        per_d     = per_q;
        phase_d   = phase_q;
        val_d     = val_q;

        if (tick) begin
            per_d = per_end ? '0 : per_q + 10'd1;
        end

        if (step) begin
            unique case (mode_q)
                MODE_BLINK: begin
                    phase_d = !phase_q;
                    val_d   = phase_q ? '0 : pattern_q;
                end
                MODE_CHASE: val_d = rot;
                MODE_BAR:   val_d = bar_of(level_i);
                default:    val_d = val_q;
            endcase
        end

        // A load overrides everything above, including a coincident step.
        if (cfg_load) begin
            mode_d    = mode_e'(mode_i);
            pattern_d = pattern_i;
            period_d  = (period_i == 10'd0) ? 10'd1 : period_i;
            presc_d   = '0;
            per_d     = '0;
            phase_d   = 1'b1;
            unique case (mode_e'(mode_i))
                MODE_CHASE: val_d = LED_WIDTH'(1);
                MODE_BAR:   val_d = bar_of(level_i);
                default:    val_d = pattern_i;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_STATIC;
            pattern_q <= '0;
            period_q  <= 10'd1;
            presc_q   <= '0;
            per_q     <= '0;
            phase_q   <= 1'b0;
            val_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            presc_q   <= presc_d;
            per_q     <= per_d;
            phase_q   <= phase_d;
            val_q     <= val_d;
        end
    end

    assign val_o  = val_q;
    assign step_o = step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: an arithmetic reference model predicts
// each cycle's val_o/step_o, a negedge monitor pops and compares.
module tb_led_pattern_gen;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [7:0]  pattern_i = '0;
    logic [9:0]  period_i = '0;
    logic [13:0] level_i = '0;
    logic [7:0]  val_o;
    logic        step_o;

    led_pattern_gen #(.LED_WIDTH(8), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .mode_i    (mode_i),
        .pattern_i (pattern_i),
        .period_i  (period_i),
        .level_i   (level_i),
        .val_o     (val_o),
        .step_o    (step_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic       step;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: cycles since last load/reset and steps taken since then.
    int unsigned m_t, m_s, m_per;
    logic [1:0]  m_mode;
    logic [7:0]  m_pat;
    logic [13:0] m_lvl;

    function automatic logic [7:0] bar_ref(input logic [13:0] lvl);
        int n;
        n = int'(lvl) / 2048 + (((int'(lvl) % 2048) != 0) ? 1 : 0);
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic [7:0] model_val();
        case (m_mode)
            2'd0:    return m_pat;
            2'd1:    return ((m_s % 2) == 0) ? m_pat : 8'h00;
            2'd2:    return 8'(1 << (m_s % 8));
            default: return bar_ref(m_lvl);
        endcase
    endfunction

    function automatic logic pred_step();
        return (((m_t + 1) % TD) == 0) && ((((m_t + 1) / TD) % m_per) == 0);
    endfunction

    task automatic model_reset();
        m_mode = 2'd0; m_pat = 8'h00; m_per = 1; m_t = 0; m_s = 0; m_lvl = '0;
    endtask

    task automatic cyc(input logic rst, input logic ld, input logic [1:0] md,
                       input logic [7:0] pat, input logic [9:0] per, input logic [13:0] lvl);
        exp_t e;
        rst_n = rst; cfg_load = ld; mode_i = md; pattern_i = pat; period_i = per; level_i = lvl;
        if (!rst) begin
            e.val = 8'h00; e.step = 1'b0;
            sb.push_back(e);
            model_reset();
        end else begin
            e.val  = model_val();
            e.step = !ld && pred_step();
            sb.push_back(e);
            if (ld) begin
                m_mode = md; m_pat = pat; m_per = (per == 10'd0) ? 1 : int'(per);
                m_t = 0; m_s = 0; m_lvl = lvl;
            end else begin
                if (e.step) begin
                    m_s++;
                    m_lvl = lvl;
                end
                m_t++;
            end
        end
        @(posedge clk); #1;
    endtask

    // Unloaded cycles with random mode/pattern/period on the inputs.
    task automatic idle(input int n, input logic [13:0] lvl);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 2'($urandom), 8'($urandom), 10'($urandom), lvl);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (val_o !== e.val || step_o !== e.step) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: val_o=%02h step_o=%b, expected val_o=%02h step_o=%b",
                         vectors, $time, val_o, step_o, e.val, e.step);
            end
        end
    end

    initial begin
        logic [13:0] lvls[5];
        logic        found;
        lvls[0] = 14'h0000; lvls[1] = 14'h0001; lvls[2] = 14'h0800;
        lvls[3] = 14'h0801; lvls[4] = 14'h3FFF;
        model_reset();
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 10'd0, '0);
        idle(12, '0);

        cyc(1'b1, 1'b1, 2'd0, 8'hA5, 10'd1, '0);
        idle(100, '0);

        cyc(1'b1, 1'b1, 2'd1, 8'h0F, 10'd2, '0);
        idle(24, '0);

        cyc(1'b1, 1'b1, 2'd2, 8'h00, 10'd1, '0);
        idle(40, '0);

        cyc(1'b1, 1'b1, 2'd3, 8'h00, 10'd1, lvls[0]);
        idle(3, lvls[0]);
        for (int k = 1; k < 5; k++) idle(4, lvls[k]);
        idle(4, 14'h0000);

        cyc(1'b1, 1'b1, 2'd2, 8'h00, 10'd0, '0);
        idle(20, '0);

        cyc(1'b1, 1'b1, 2'd2, 8'h00, 10'd2, '0);
        idle(5, '0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pred_step()) found = 1'b1;
            else idle(1, '0);
        end
        if (!found) begin
            miscompares++;
            $display("FAIL collision_setup: no step predicted within 40 cycles, expected one");
        end
        cyc(1'b1, 1'b1, 2'd2, 8'h00, 10'd2, '0);
        idle(20, '0);

        cyc(1'b1, 1'b1, 2'd2, 8'h00, 10'd1, '0);
        idle(10, '0);
        cyc(1'b0, 1'b0, 2'd2, 8'h00, 10'd1, '0);
        cyc(1'b0, 1'b0, 2'd2, 8'h00, 10'd1, '0);
        idle(20, 14'h3FFF);
        cyc(1'b1, 1'b1, 2'd1, 8'h3C, 10'd1, '0);
        idle(12, '0);

        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            logic [13:0] lv;
            r  = $urandom_range(0, 199);
            lv = ($urandom_range(0, 1) == 0) ? lvls[$urandom_range(0, 4)] : 14'($urandom);
            cyc(r != 0, r < 12, 2'($urandom), 8'($urandom), 10'($urandom_range(0, 3)), lv);
        end

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
        end
        if (vectors < 12) begin
            miscompares++;
            $display("FAIL coverage: %0d vectors checked, expected at least 12", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
